// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer in front of data_mem
module dmem_arbiter #(
    parameter int MEM_DEPTH  = 256,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  r0_req_valid,
    output logic                  r0_req_ready,
    input  logic                  r0_req_we,
    input  logic [DATA_WIDTH-1:0] r0_req_addr,
    input  logic [DATA_WIDTH-1:0] r0_req_wdata,
    output logic                  r0_rsp_valid,
    output logic [DATA_WIDTH-1:0] r0_rsp_rdata,
    output logic                  r0_rsp_err,

    input  logic                  r1_req_valid,
    output logic                  r1_req_ready,
    input  logic                  r1_req_we,
    input  logic [DATA_WIDTH-1:0] r1_req_addr,
    input  logic [DATA_WIDTH-1:0] r1_req_wdata,
    output logic                  r1_rsp_valid,
    output logic [DATA_WIDTH-1:0] r1_rsp_rdata,
    output logic                  r1_rsp_err,

    output logic                  mem_cs_mem_write,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    // Full-width limit so that huge addresses never alias into range.
    localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t                state;
    logic                  last_grant;
    logic                  grant;
    logic                  grant_q;
    logic                  we_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  rsp_valid0_q;
    logic                  rsp_valid1_q;
    logic                  rsp_err0_q;
    logic                  rsp_err1_q;
    logic [DATA_WIDTH-1:0] rsp_rdata0_q;
    logic [DATA_WIDTH-1:0] rsp_rdata1_q;

    logic                  accept;
    logic                  sel_we;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] cap_rdata;

    // Round-robin pick: a lone requester wins, contention goes to the port not served last.
    always_comb begin
        grant = ~last_grant;
        if (r0_req_valid && !r1_req_valid) begin
            grant = 1'b0;
        end else if (r1_req_valid && !r0_req_valid) begin
            grant = 1'b1;
        end
    end

    // Payload of the granted port and its range check.
    always_comb begin
        sel_we    = grant ? r1_req_we    : r0_req_we;
        sel_addr  = grant ? r1_req_addr  : r0_req_addr;
        sel_wdata = grant ? r1_req_wdata : r0_req_wdata;
        sel_err   = (sel_addr >= DEPTH_W);
        accept    = (state == IDLE) && (grant ? r1_req_valid : r0_req_valid);
        cap_rdata = (!we_q && !err_q) ? mem_read_data : '0;
    end

    assign r0_req_ready = (state == IDLE) && !rst && !grant;
    assign r1_req_ready = (state == IDLE) && !rst &&  grant;

    // Write strobe is gated by rst directly so a reset during ISSUE kills the write.
    assign mem_cs_mem_write = (state == ISSUE) && we_q && !err_q && !rst;
    assign mem_addr         = rst ? '0 : mem_addr_q;
    assign mem_write_data   = rst ? '0 : mem_wdata_q;

    assign r0_rsp_valid = rsp_valid0_q && !rst;
    assign r1_rsp_valid = rsp_valid1_q && !rst;
    assign r0_rsp_err   = rsp_err0_q && !rst;
    assign r1_rsp_err   = rsp_err1_q && !rst;
    assign r0_rsp_rdata = rst ? '0 : rsp_rdata0_q;
    assign r1_rsp_rdata = rst ? '0 : rsp_rdata1_q;

    // Sequencer: accept in IDLE, drive memory in ISSUE, register the response in CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_err0_q   <= 1'b0;
            rsp_err1_q   <= 1'b0;
            rsp_rdata0_q <= '0;
            rsp_rdata1_q <= '0;
        end else begin
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_err0_q   <= 1'b0;
            rsp_err1_q   <= 1'b0;
            rsp_rdata0_q <= '0;
            rsp_rdata1_q <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant  <= grant;
                        grant_q     <= grant;
                        we_q        <= sel_we;
                        err_q       <= sel_err;
                        mem_addr_q  <= sel_err ? '0 : sel_addr;
                        mem_wdata_q <= sel_wdata;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    state <= IDLE;
                    if (grant_q) begin
                        rsp_valid1_q <= 1'b1;
                        rsp_err1_q   <= err_q;
                        rsp_rdata1_q <= cap_rdata;
                    end else begin
                        rsp_valid0_q <= 1'b1;
                        rsp_err0_q   <= err_q;
                        rsp_rdata0_q <= cap_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req_valid, r0_req_ready, r0_req_we, r0_rsp_valid, r0_rsp_err;
    logic [31:0] r0_req_addr, r0_req_wdata, r0_rsp_rdata;
    logic        r1_req_valid, r1_req_ready, r1_req_we, r1_rsp_valid, r1_rsp_err;
    logic [31:0] r1_req_addr, r1_req_wdata, r1_rsp_rdata;
    logic        mem_cs_mem_write;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_we(r0_req_we),
        .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_err(r0_rsp_err),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_we(r1_req_we),
        .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_err(r1_rsp_err),
        .mem_cs_mem_write(mem_cs_mem_write), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // data_mem stand-in: registered read, word index folds like the real part
    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_cs_mem_write) mem[mem_addr[7:0]] <= mem_write_data;
        mem_read_data <= mem[mem_addr[7:0]];
    end

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct { int due; int port; logic err; logic [31:0] rdata; } rsp_t;

    req_t q0[$];
    req_t q1[$];
    rsp_t rq[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_mode = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model state: accept window, round-robin memory, pending memory-port activity
    int          cyc = 0;
    int          m_next_ok = 0;
    int          m_last = 1;
    int          iss_cyc = -1;
    logic [31:0] iss_addr, iss_wdata;
    logic        iss_cs;
    bit          acc0_hs, acc1_hs;
    int          win;
    bit          permitted, e0, e1, ev;
    rsp_t        e, n;
    req_t        a;
    logic        a_err;

    always @(negedge clk) begin
        acc0_hs = r0_req_valid && r0_req_ready;
        acc1_hs = r1_req_valid && r1_req_ready;
        if (rst) begin
            check_eq("rst_flags", 32'({r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid,
                                       r0_rsp_err, r1_rsp_err, mem_cs_mem_write}), 32'd0);
            check_eq("rst_rdata0", r0_rsp_rdata, 32'd0);
            check_eq("rst_rdata1", r1_rsp_rdata, 32'd0);
            check_eq("rst_mem_addr", mem_addr, 32'd0);
            check_eq("rst_mem_wdata", mem_write_data, 32'd0);
            m_last    = 1;
            m_next_ok = cyc + 1;
            iss_cyc   = -1;
            rq.delete();
        end else begin
            permitted = (cyc >= m_next_ok);
            if (r0_req_valid && r1_req_valid) win = 1 - m_last;
            else if (r0_req_valid)            win = 0;
            else                              win = 1;
            e0 = permitted && r0_req_valid && (win == 0);
            e1 = permitted && r1_req_valid && (win == 1);
            if (r0_req_valid) check_eq("ready0", 32'(r0_req_ready), 32'(e0));
            if (r1_req_valid) check_eq("ready1", 32'(r1_req_ready), 32'(e1));
            check_eq("ready_onehot", 32'(r0_req_ready & r1_req_ready), 32'd0);

            if (cyc == iss_cyc) begin
                check_eq("issue_cs", 32'(mem_cs_mem_write), 32'(iss_cs));
                check_eq("issue_addr", mem_addr, iss_addr);
                check_eq("issue_wdata", mem_write_data, iss_wdata);
                if (iss_cs) ref_mem[iss_addr[7:0]] = iss_wdata;
            end else begin
                check_eq("idle_cs", 32'(mem_cs_mem_write), 32'd0);
            end

            ev = 0;
            e  = '{due: 0, port: 0, err: 1'b0, rdata: 32'd0};
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e  = rq.pop_front();
                ev = 1;
            end
            check_eq("rsp_valid0", 32'(r0_rsp_valid), 32'(ev && e.port == 0));
            check_eq("rsp_valid1", 32'(r1_rsp_valid), 32'(ev && e.port == 1));
            check_eq("rsp_err0", 32'(r0_rsp_err), 32'(ev && e.port == 0 && e.err));
            check_eq("rsp_err1", 32'(r1_rsp_err), 32'(ev && e.port == 1 && e.err));
            check_eq("rsp_rdata0", r0_rsp_rdata, (ev && e.port == 0) ? e.rdata : 32'd0);
            check_eq("rsp_rdata1", r1_rsp_rdata, (ev && e.port == 1) ? e.rdata : 32'd0);

            if (e0 || e1) begin
                a = e0 ? '{we: r0_req_we, addr: r0_req_addr, wdata: r0_req_wdata}
                       : '{we: r1_req_we, addr: r1_req_addr, wdata: r1_req_wdata};
                a_err = (a.addr >= 32'(DEPTH));
                n.due   = cyc + 3;
                n.port  = e0 ? 0 : 1;
                n.err   = a_err;
                n.rdata = (!a.we && !a_err) ? ref_mem[a.addr[7:0]] : 32'd0;
                rq.push_back(n);
                iss_cyc   = cyc + 1;
                iss_addr  = a_err ? 32'd0 : a.addr;
                iss_wdata = a.wdata;
                iss_cs    = a.we && !a_err;
                m_last    = win;
                m_next_ok = cyc + 3;
            end
        end
        cyc++;
    end

    task automatic drive(input int port, input req_t r);
        if (port == 0) begin
            r0_req_valid = 1'b1; r0_req_we = r.we; r0_req_addr = r.addr; r0_req_wdata = r.wdata;
        end else begin
            r1_req_valid = 1'b1; r1_req_we = r.we; r1_req_addr = r.addr; r1_req_wdata = r.wdata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (acc0_hs) r0_req_valid = 1'b0;
        if (acc1_hs) r1_req_valid = 1'b0;
        if (rand_mode && r0_req_valid && $urandom_range(0, 15) == 0) r0_req_valid = 1'b0;
        if (rand_mode && r1_req_valid && $urandom_range(0, 15) == 0) r1_req_valid = 1'b0;
        if (!r0_req_valid && q0.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0))
            drive(0, q0.pop_front());
        if (!r1_req_valid && q1.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0))
            drive(1, q1.pop_front());
    endtask

    task automatic push(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r = '{we: we, addr: addr, wdata: wdata};
        if (port == 0) q0.push_back(r);
        else           q1.push_back(r);
    endtask

    task automatic run_idle(input string tag);
        int n_t;
        bit idle;
        n_t  = 0;
        idle = 0;
        do begin
            tick();
            n_t++;
            idle = q0.size() == 0 && q1.size() == 0 && !r0_req_valid && !r1_req_valid &&
                   rq.size() == 0 && cyc > iss_cyc + 1;
        end while (!idle && n_t < 400);
        check_eq({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd255;
            2:       return 32'd256;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom);
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int n_w;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'(i) * 32'h0100_0193 + 32'h0000_1234;
            ref_mem[i] = 32'(i) * 32'h0100_0193 + 32'h0000_1234;
        end
        r0_req_valid = 0; r0_req_we = 0; r0_req_addr = 0; r0_req_wdata = 0;
        r1_req_valid = 0; r1_req_we = 0; r1_req_addr = 0; r1_req_wdata = 0;
        do_reset(3);

        push(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        push(0, 1'b0, 32'd5, 32'd0);
        run_idle("wr_rd_p0");

        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 32'd1, 32'd0);
            push(1, 1'b0, 32'd2, 32'd0);
        end
        run_idle("contention");

        push(1, 1'b1, 32'd256, 32'h0000_1234);
        push(1, 1'b0, 32'd0, 32'd0);
        run_idle("out_of_range");

        push(0, 1'b1, 32'd255, 32'hA5A5_A5A5);
        push(0, 1'b0, 32'd255, 32'd0);
        push(1, 1'b1, 32'hFFFF_FFFF, 32'h0BAD_0BAD);
        run_idle("top_word");

        push(0, 1'b1, 32'd7, 32'h0000_0055);
        n_w = 0;
        do begin
            tick();
            n_w++;
        end while (!acc0_hs && n_w < 50);
        check_eq("rst_issue_accept", 32'(acc0_hs), 32'd1);
        do_reset(1);
        push(0, 1'b0, 32'd7, 32'd0);
        push(1, 1'b0, 32'd3, 32'd0);
        run_idle("rst_in_issue");

        for (int i = 0; i < 4; i++) push(0, 1'b0, 32'(i), 32'd0);
        run_idle("back_to_back");

        rand_mode = 1;
        for (int i = 0; i < 600; i++) begin
            if (q0.size() < 2) push(0, 1'($urandom_range(0, 1)), rand_addr(), 32'($urandom));
            if (q1.size() < 2) push(1, 1'($urandom_range(0, 1)), rand_addr(), 32'($urandom));
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        rand_mode = 0;
        run_idle("random");

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
